ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//   Shares one 64x8 dual-port RAM between two requesters, A and B. Each requester has
//   one command channel that carries either a read or a write. The write port and the
//   read port are arbitrated independently, each with round-robin priority.
//   The block drives the RAM write and read ports from registers, and returns read data
//   with a per-requester valid strobe. The RAM's rd_clk and wr_clk are tied to clk.
// PARAMETERS
//   DW  8  data width; must match the RAM word width
//   AW  6  address width; the RAM depth is 2**AW
// PORTS
//   clk          in   1   single clock; all logic on posedge
//   rst          in   1   asynchronous, active-high reset
//   a_req        in   1   A command valid; held until a_gnt
//   a_we         in   1   A command type: 1 = write, 0 = read
//   a_addr       in   AW  A address
//   a_wdata      in   DW  A write data
//   a_gnt        out  1   A command accepted this cycle (combinational)
//   a_rvalid     out  1   rdata holds A's read result this cycle
//   b_req/b_we/b_addr/b_wdata/b_gnt/b_rvalid       same as A, for requester B
//   rdata        out  DW  read data, shared by A and B (driven from ram_q)
//   ram_wr_en    out  1   to RAM wr_en (registered)
//   ram_wr_addr  out  AW  to RAM wr_addr (registered)
//   ram_data     out  DW  to RAM data (registered)
//   ram_rd_addr  out  AW  to RAM rd_addr (registered)
//   ram_q        in   DW  from RAM q (registered inside the RAM)
// BEHAVIOUR
//   Reset: clk is the only clock. rst is asynchronous and active-high.
//     - Registered outputs clear immediately on rst: ram_wr_en, ram_wr_addr, ram_data,
//       ram_rd_addr, a_rvalid and b_rvalid all go to 0.
//     - a_gnt and b_gnt are forced to 0 while rst is high.
//     - Both priority bits reset to favour A.
//     - RAM contents are not touched.
//   Handshake: a command transfers on the clk edge that ends a cycle with req=1 and gnt=1.
//     - The requester must hold we, addr and wdata stable until gnt.
//     - A requester may present a new command in the cycle after gnt.
//   Write port arbitration (wr_prio bit):
//     - Candidates are requesters with req=1 and we=1.
//     - With one candidate, it is granted.
//     - With two candidates, the one named by wr_prio is granted.
//     - After any write grant, wr_prio points to the non-granted requester.
//   Read port arbitration (rd_prio bit): identical rules, using we=0 candidates.
//   Mixed commands: a write by one requester and a read by the other in the same cycle
//     are both granted.
//   Write path, grant in cycle N:
//     - At the end of N: ram_wr_en=1 and ram_wr_addr/ram_data load the winner's values.
//     - The RAM writes at the end of N+1.
//     - ram_wr_en returns to 0 at the end of N+1 unless a new write was granted in N+1.
//   Read path, grant in cycle N:
//     - At the end of N: ram_rd_addr loads the address.
//     - The RAM registers q at the end of N+1.
//     - The owner's rvalid is 1 during N+2 only, and rdata = ram_q.
//     - Fixed 2-cycle latency, one read per cycle, in order.
//     - A 2-stage owner/valid shift register tracks the read in flight.
//   Same-address write and read granted in the same cycle: the read returns the OLD data,
//     because the RAM reads and writes on the same edge.
//   A write granted in cycle N is visible to a read granted in cycle N+1 or later.
//   When idle, ram_rd_addr holds its last value and rvalid stays 0.
//   Address width: addresses are AW bits with no wrap or range check; every value is legal.
//   Reset mid-operation:
//     - Writes registered but not yet performed are lost, because ram_wr_en clears.
//     - Reads in flight are dropped with no rvalid.
//     - Arbitration restarts from A.
//   a_rvalid and b_rvalid are never 1 in the same cycle.
// TESTING
//   1. A writes 0x5A to addr 3 in cycle 0, then reads addr 3 in cycle 2
//      -> a_rvalid=1 and rdata=0x5A in cycle 4.
//   2. A and B both request writes in cycles 0-3 (A to addrs 0-3, B to addrs 8-11)
//      -> grants alternate A,B,A,B; each requester is granted in every other cycle.
//   3. In one cycle, A writes 0xFF to addr 7 while B reads addr 7 (old value 0x11)
//      -> both are granted; b_rvalid returns 0x11; a B re-read returns 0xFF.
//   4. A and B issue back-to-back reads of addrs 1 and 2 for 4 cycles
//      -> one rvalid per cycle, 2-cycle latency each, correct owner and data, never both.
//   5. rst pulses high asynchronously in the cycle after a write and a read are granted
//      -> ram_wr_en=0 and rvalid=0 at once; the write is not performed; A wins the next
//      contended grant.
//   6. Write addrs 0 and 63 with 0x01 and 0x3F, then read both back
//      -> data matches; no aliasing at the address extremes.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one 64x8 dual-port RAM between requesters A and B.
// Write and read ports are arbitrated independently; reads return after two cycles.
module ram_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_stage_t;

  owner_e          r_wr_prio;
  owner_e          r_rd_prio;
  rd_stage_t       r_rd_s1;
  rd_stage_t       r_rd_s2;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic [AW-1:0]   r_rd_addr;

  logic w_a_wr_cand;
  logic w_b_wr_cand;
  logic w_a_rd_cand;
  logic w_b_rd_cand;
  logic w_a_wr_gnt;
  logic w_b_wr_gnt;
  logic w_a_rd_gnt;
  logic w_b_rd_gnt;

  assign w_a_wr_cand = a_req &  a_we;
  assign w_b_wr_cand = b_req &  b_we;
  assign w_a_rd_cand = a_req & ~a_we;
  assign w_b_rd_cand = b_req & ~b_we;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_a_wr_gnt = 1'b0;
    w_b_wr_gnt = 1'b0;
    w_a_rd_gnt = 1'b0;
    w_b_rd_gnt = 1'b0;

    if (w_a_wr_cand && w_b_wr_cand) begin
      w_a_wr_gnt = (r_wr_prio == OWN_A);
      w_b_wr_gnt = (r_wr_prio == OWN_B);
    end else begin
      w_a_wr_gnt = w_a_wr_cand;
      w_b_wr_gnt = w_b_wr_cand;
    end

    if (w_a_rd_cand && w_b_rd_cand) begin
      w_a_rd_gnt = (r_rd_prio == OWN_A);
      w_b_rd_gnt = (r_rd_prio == OWN_B);
    end else begin
      w_a_rd_gnt = w_a_rd_cand;
      w_b_rd_gnt = w_b_rd_cand;
    end

    // Grants must not leak out while the block is held in reset.
    if (rst) begin
      w_a_wr_gnt = 1'b0;
      w_b_wr_gnt = 1'b0;
      w_a_rd_gnt = 1'b0;
      w_b_rd_gnt = 1'b0;
    end
  end

  assign a_gnt = w_a_wr_gnt | w_a_rd_gnt;
  assign b_gnt = w_b_wr_gnt | w_b_rd_gnt;

  // Write port: register the winner's command; the RAM commits it one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_prio <= OWN_A;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_wr_en <= w_a_wr_gnt | w_b_wr_gnt;
      if (w_a_wr_gnt) begin
        r_wr_addr <= a_addr;
        r_wr_data <= a_wdata;
        r_wr_prio <= OWN_B;
      end else if (w_b_wr_gnt) begin
        r_wr_addr <= b_addr;
        r_wr_data <= b_wdata;
        r_wr_prio <= OWN_A;
      end
    end
  end

  // Read port: address register plus a two-stage owner/valid tracker matching RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_prio <= OWN_A;
      r_rd_addr <= '0;
      r_rd_s1   <= '{valid: 1'b0, owner: OWN_A};
      r_rd_s2   <= '{valid: 1'b0, owner: OWN_A};
    end else begin
      r_rd_s1 <= '{valid: w_a_rd_gnt | w_b_rd_gnt,
                   owner: (w_b_rd_gnt ? OWN_B : OWN_A)};
      r_rd_s2 <= r_rd_s1;
      if (w_a_rd_gnt) begin
        r_rd_addr <= a_addr;
        r_rd_prio <= OWN_B;
      end else if (w_b_rd_gnt) begin
        r_rd_addr <= b_addr;
        r_rd_prio <= OWN_A;
      end
    end
  end

  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_wr_addr;
  assign ram_data    = r_wr_data;
  assign ram_rd_addr = r_rd_addr;

  // A single owner field makes simultaneous rvalids impossible by construction.
  assign a_rvalid = r_rd_s2.valid && (r_rd_s2.owner == OWN_A);
  assign b_rvalid = r_rd_s2.valid && (r_rd_s2.owner == OWN_B);
  assign rdata    = ram_q;

endmodule
